// File: rtl/regfile_wb_queue.sv
// Write-back queue for the lagarto0 register file: arbitrates ALU/MEM results into an in-order
// FIFO and keeps a busy scoreboard of pending loads. Define WB_FWD_EN to enable the forwarding lookup.
module regfile_wb_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     alu_valid_i,
  input  logic [4:0]               alu_rd_i,
  input  logic [XLEN-1:0]          alu_data_i,
  output logic                     alu_ready_o,
  input  logic                     mem_valid_i,
  input  logic [4:0]               mem_rd_i,
  input  logic [XLEN-1:0]          mem_data_i,
  output logic                     mem_ready_o,
  input  logic                     issue_i,
  input  logic [4:0]               issue_rd_i,
  input  logic                     wb_stall_i,
  output logic [4:0]               rd_o,
  output logic [XLEN-1:0]          datord_o,
  output logic                     wren_o,
  output logic [31:0]              busy_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  input  logic [4:0]               fwd_rs_i,
  output logic                     fwd_hit_o,
  output logic [XLEN-1:0]          fwd_data_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     busy_q, busy_d;
  logic            src_q  [DEPTH];
  logic            src_d  [DEPTH];
  logic [4:0]      rd_q   [DEPTH];
  logic [4:0]      rd_d   [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic [XLEN-1:0] data_d [DEPTH];

  logic            empty, full, pop, space, push;
  logic            push_src;
  logic [4:0]      push_rd;
  logic [XLEN-1:0] push_data;

  always_comb begin
    empty     = (count_q == '0);
    full      = (count_q == CW'(DEPTH));
    pop       = !empty && !wb_stall_i;
    space     = !full || pop;
    push_src  = mem_valid_i;
    push_rd   = mem_valid_i ? mem_rd_i : alu_rd_i;
    push_data = mem_valid_i ? mem_data_i : alu_data_i;
    // x0 writes still handshake; they simply never enter the queue.
    push      = (mem_valid_i || alu_valid_i) && space && (push_rd != 5'd0);

    mem_ready_o = space;
    alu_ready_o = space && !mem_valid_i;
    wren_o      = pop;
    rd_o        = empty ? 5'd0 : rd_q[rd_ptr_q];
    datord_o    = empty ? '0 : data_q[rd_ptr_q];
    count_o     = count_q;
    full_o      = full;
    busy_o      = busy_q;
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    busy_d   = busy_q;
    src_d    = src_q;
    rd_d     = rd_q;
    data_d   = data_q;

    if (push) begin
      src_d[wr_ptr_q]  = push_src;
      rd_d[wr_ptr_q]   = push_rd;
      data_d[wr_ptr_q] = push_data;
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      if (src_q[rd_ptr_q]) busy_d[rd_q[rd_ptr_q]] = 1'b0;
    end
    // Set is applied after clear so a same-edge re-issue keeps the register busy.
    if (issue_i && (issue_rd_i != 5'd0)) busy_d[issue_rd_i] = 1'b1;
    busy_d[0] = 1'b0;

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      busy_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
    end
  end

  // Entry storage needs no reset: occupancy gates every read of it.
  always_ff @(posedge clk_i) begin
    src_q  <= src_d;
    rd_q   <= rd_d;
    data_q <= data_d;
  end

`ifdef WB_FWD_EN
  logic [PW-1:0] fwd_idx;

  always_comb begin
    fwd_hit_o  = 1'b0;
    fwd_data_o = '0;
    fwd_idx    = rd_ptr_q;
    // Walk oldest to youngest so the youngest match wins.
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_ptr_q + PW'(i);
      if ((CW'(i) < count_q) && (rd_q[fwd_idx] == fwd_rs_i) && (fwd_rs_i != 5'd0)) begin
        fwd_hit_o  = 1'b1;
        fwd_data_o = data_q[fwd_idx];
      end
    end
  end
`else
  logic unused_fwd_rs;

  assign unused_fwd_rs = ^fwd_rs_i;
  assign fwd_hit_o     = 1'b0;
  assign fwd_data_o    = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Self-checking bench for regfile_wb_queue: directed vector table, hand sequences for the
// scoreboard/reset/forwarding corners, then randomized traffic against a queue-based model.
module tb_regfile_wb_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
`ifdef WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            alu_valid_i;
  logic [4:0]      alu_rd_i;
  logic [XLEN-1:0] alu_data_i;
  logic            alu_ready_o;
  logic            mem_valid_i;
  logic [4:0]      mem_rd_i;
  logic [XLEN-1:0] mem_data_i;
  logic            mem_ready_o;
  logic            issue_i;
  logic [4:0]      issue_rd_i;
  logic            wb_stall_i;
  logic [4:0]      rd_o;
  logic [XLEN-1:0] datord_o;
  logic            wren_o;
  logic [31:0]     busy_o;
  logic [2:0]      count_o;
  logic            full_o;
  logic [4:0]      fwd_rs_i;
  logic            fwd_hit_o;
  logic [XLEN-1:0] fwd_data_o;

  regfile_wb_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .alu_valid_i(alu_valid_i), .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i), .alu_ready_o(alu_ready_o),
    .mem_valid_i(mem_valid_i), .mem_rd_i(mem_rd_i), .mem_data_i(mem_data_i), .mem_ready_o(mem_ready_o),
    .issue_i(issue_i), .issue_rd_i(issue_rd_i), .wb_stall_i(wb_stall_i),
    .rd_o(rd_o), .datord_o(datord_o), .wren_o(wren_o), .busy_o(busy_o),
    .count_o(count_o), .full_o(full_o),
    .fwd_rs_i(fwd_rs_i), .fwd_hit_o(fwd_hit_o), .fwd_data_o(fwd_data_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid_i = 0; alu_rd_i = 0; alu_data_i = 0;
    mem_valid_i = 0; mem_rd_i = 0; mem_data_i = 0;
    issue_i = 0; issue_rd_i = 0; wb_stall_i = 0; fwd_rs_i = 0;
  endtask

  typedef struct {
    logic av; logic [4:0] ard; logic [31:0] ad;
    logic mv; logic [4:0] mrd; logic [31:0] md;
    logic st;
    logic e_ar, e_mr, e_wren;
    logic [4:0] e_rd; logic [31:0] e_dat; logic [2:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(int av, int ard, int ad, int mv, int mrd, int md, int st,
                              int ar, int mr, int wr, int erd, int edat, int ecnt);
    vec_t v;
    v.av = av[0]; v.ard = ard[4:0]; v.ad = ad;
    v.mv = mv[0]; v.mrd = mrd[4:0]; v.md = md;
    v.st = st[0];
    v.e_ar = ar[0]; v.e_mr = mr[0]; v.e_wren = wr[0];
    v.e_rd = erd[4:0]; v.e_dat = edat; v.e_cnt = ecnt[2:0];
    return v;
  endfunction

  typedef struct { logic src; logic [4:0] rd; logic [31:0] data; } ent_t;
  ent_t        mq[$];
  logic [31:0] m_busy;
  logic        m_pop, m_space, exp_ar, exp_mr;

  task automatic model_check();
    logic        hit;
    logic [31:0] fdat;
    m_pop   = (mq.size() > 0) && !wb_stall_i;
    m_space = (mq.size() < DEPTH) || m_pop;
    exp_mr  = m_space;
    exp_ar  = m_space && !mem_valid_i;
    hit = 0; fdat = 0;
    foreach (mq[i]) if (mq[i].rd == fwd_rs_i && fwd_rs_i != 0) begin hit = 1; fdat = mq[i].data; end
    chk("rnd_alu_ready", alu_ready_o, exp_ar);
    chk("rnd_mem_ready", mem_ready_o, exp_mr);
    chk("rnd_wren", wren_o, m_pop);
    chk("rnd_rd", rd_o, (mq.size() > 0) ? mq[0].rd : 5'd0);
    chk("rnd_data", datord_o, (mq.size() > 0) ? mq[0].data : 32'd0);
    chk("rnd_count", count_o, mq.size());
    chk("rnd_full", full_o, mq.size() == DEPTH);
    chk("rnd_busy", busy_o, m_busy);
    chk("rnd_fwd_hit", fwd_hit_o, FWD ? hit : 1'b0);
    chk("rnd_fwd_data", fwd_data_o, FWD ? fdat : 32'd0);
  endtask

  task automatic model_edge();
    ent_t e;
    if (rst_i) begin
      mq.delete();
      m_busy = 0;
    end else begin
      if (m_pop) begin
        e = mq.pop_front();
        if (e.src) m_busy[e.rd] = 1'b0;
      end
      if (issue_i && issue_rd_i != 0) m_busy[issue_rd_i] = 1'b1;
      if ((mem_valid_i || alu_valid_i) && m_space) begin
        e.src  = mem_valid_i;
        e.rd   = mem_valid_i ? mem_rd_i : alu_rd_i;
        e.data = mem_valid_i ? mem_data_i : alu_data_i;
        if (e.rd != 0) mq.push_back(e);
      end
    end
  endtask

  vec_t tbl[20];

  initial begin
    logic a_hold, m_hold;

    tbl[0]  = mk(1,5,'h1234, 0,0,0, 0, 1,1,0, 0,0,0);
    tbl[1]  = mk(0,0,0,      0,0,0, 0, 1,1,1, 5,'h1234,1);
    tbl[2]  = mk(0,0,0,      0,0,0, 0, 1,1,0, 0,0,0);
    tbl[3]  = mk(1,3,'h33,   1,4,'h44, 0, 0,1,0, 0,0,0);
    tbl[4]  = mk(1,3,'h33,   0,0,0, 0, 1,1,1, 4,'h44,1);
    tbl[5]  = mk(0,0,0,      0,0,0, 0, 1,1,1, 3,'h33,1);
    tbl[6]  = mk(0,0,0,      0,0,0, 0, 1,1,0, 0,0,0);
    tbl[7]  = mk(1,10,'hA0,  0,0,0, 1, 1,1,0, 0,0,0);
    tbl[8]  = mk(1,11,'hA1,  0,0,0, 1, 1,1,0, 10,'hA0,1);
    tbl[9]  = mk(1,12,'hA2,  0,0,0, 1, 1,1,0, 10,'hA0,2);
    tbl[10] = mk(1,13,'hA3,  0,0,0, 1, 1,1,0, 10,'hA0,3);
    tbl[11] = mk(1,14,'hA4,  0,0,0, 1, 0,0,0, 10,'hA0,4);
    tbl[12] = mk(1,14,'hA4,  0,0,0, 0, 1,1,1, 10,'hA0,4);
    tbl[13] = mk(0,0,0,      0,0,0, 0, 1,1,1, 11,'hA1,4);
    tbl[14] = mk(0,0,0,      0,0,0, 0, 1,1,1, 12,'hA2,3);
    tbl[15] = mk(0,0,0,      0,0,0, 0, 1,1,1, 13,'hA3,2);
    tbl[16] = mk(0,0,0,      0,0,0, 0, 1,1,1, 14,'hA4,1);
    tbl[17] = mk(0,0,0,      0,0,0, 0, 1,1,0, 0,0,0);
    tbl[18] = mk(0,0,0,      1,0,'h77, 0, 0,1,0, 0,0,0);
    tbl[19] = mk(0,0,0,      0,0,0, 0, 1,1,0, 0,0,0);

    idle_inputs();
    rst_i = 1;
    tick(); tick();
    #4;
    chk("reset_count", count_o, 0);
    chk("reset_full", full_o, 0);
    chk("reset_wren", wren_o, 0);
    chk("reset_rd", rd_o, 0);
    chk("reset_data", datord_o, 0);
    chk("reset_busy", busy_o, 0);
    chk("reset_fwd_hit", fwd_hit_o, 0);
    chk("reset_fwd_data", fwd_data_o, 0);
    tick();
    rst_i = 0;

    foreach (tbl[i]) begin
      alu_valid_i = tbl[i].av; alu_rd_i = tbl[i].ard; alu_data_i = tbl[i].ad;
      mem_valid_i = tbl[i].mv; mem_rd_i = tbl[i].mrd; mem_data_i = tbl[i].md;
      wb_stall_i  = tbl[i].st;
      #4;
      chk($sformatf("vec%0d_alu_ready", i), alu_ready_o, tbl[i].e_ar);
      chk($sformatf("vec%0d_mem_ready", i), mem_ready_o, tbl[i].e_mr);
      chk($sformatf("vec%0d_wren", i), wren_o, tbl[i].e_wren);
      chk($sformatf("vec%0d_rd", i), rd_o, tbl[i].e_rd);
      chk($sformatf("vec%0d_data", i), datord_o, tbl[i].e_dat);
      chk($sformatf("vec%0d_count", i), count_o, tbl[i].e_cnt);
      chk($sformatf("vec%0d_full", i), full_o, tbl[i].e_cnt == 3'd4);
      tick();
    end
    idle_inputs();

    // Scoreboard set, then cleared by the MEM pop.
    issue_i = 1; issue_rd_i = 7;
    #4; chk("sb_before_issue", busy_o, 0);
    tick();
    issue_i = 0; mem_valid_i = 1; mem_rd_i = 7; mem_data_i = 'hAA;
    #4; chk("sb_set", busy_o, 32'h80);
    chk("sb_mem_ready", mem_ready_o, 1);
    tick();
    mem_valid_i = 0;
    #4; chk("sb_pop_wren", wren_o, 1);
    chk("sb_pop_rd", rd_o, 7);
    chk("sb_pop_data", datord_o, 'hAA);
    chk("sb_busy_until_pop", busy_o, 32'h80);
    tick();
    #4; chk("sb_cleared", busy_o, 0);
    chk("sb_no_wren", wren_o, 0);

    // Same-edge re-issue wins over the clear.
    issue_i = 1; issue_rd_i = 7;
    tick();
    issue_i = 0; mem_valid_i = 1; mem_rd_i = 7; mem_data_i = 'hBB;
    tick();
    mem_valid_i = 0; issue_i = 1; issue_rd_i = 7;
    #4; chk("sb_reissue_wren", wren_o, 1);
    tick();
    issue_i = 0;
    #4; chk("sb_set_wins", busy_o, 32'h80);

    // Mid-operation reset discards the queue and scoreboard.
    wb_stall_i = 1;
    for (int k = 1; k <= 3; k++) begin
      alu_valid_i = 1; alu_rd_i = k[4:0]; alu_data_i = 'h100 + k;
      tick();
    end
    alu_valid_i = 0;
    #4; chk("rst_pre_count", count_o, 3);
    wb_stall_i = 0; rst_i = 1;
    tick();
    rst_i = 0;
    #4; chk("rst_count", count_o, 0);
    chk("rst_wren", wren_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_rd", rd_o, 0);

    // Forwarding lookup: youngest match, push not visible in its own cycle.
    wb_stall_i = 1; fwd_rs_i = 9;
    alu_valid_i = 1; alu_rd_i = 9; alu_data_i = 'h11;
    #4; chk("fwd_same_cycle_hit", fwd_hit_o, 0);
    tick();
    alu_data_i = 'h22;
    #4; chk("fwd_one_hit", fwd_hit_o, FWD);
    chk("fwd_one_data", fwd_data_o, FWD ? 32'h11 : 32'h0);
    tick();
    alu_valid_i = 0;
    #4; chk("fwd_young_hit", fwd_hit_o, FWD);
    chk("fwd_young_data", fwd_data_o, FWD ? 32'h22 : 32'h0);
    fwd_rs_i = 0;
    #1; chk("fwd_x0_hit", fwd_hit_o, 0);
    chk("fwd_x0_data", fwd_data_o, 0);
    tick();
    idle_inputs();
    rst_i = 1;
    tick();
    rst_i = 0;

    // Randomized traffic against the queue model.
    mq.delete();
    m_busy = 0;
    a_hold = 0; m_hold = 0;
    for (int n = 0; n < 3000; n++) begin
      rst_i = ($urandom_range(0, 299) == 0);
      if (!a_hold) begin
        alu_valid_i = ($urandom_range(0, 1) == 1);
        alu_rd_i    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
        alu_data_i  = $urandom;
      end
      if (!m_hold) begin
        mem_valid_i = ($urandom_range(0, 2) == 0);
        mem_rd_i    = 5'($urandom_range(0, 7));
        mem_data_i  = $urandom;
      end
      wb_stall_i = ($urandom_range(0, 2) == 0);
      issue_i    = ($urandom_range(0, 3) == 0);
      issue_rd_i = 5'($urandom_range(0, 7));
      fwd_rs_i   = 5'($urandom_range(0, 7));
      #4;
      model_check();
      a_hold = alu_valid_i && !exp_ar && !rst_i;
      m_hold = mem_valid_i && !exp_mr && !rst_i;
      model_edge();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_wb_queue.md
Name: regfile_wb_queue

Overview:
- Write-side companion of the lagarto0 register file. It collects register results from two producers: the single-cycle ALU path and the multi-cycle load/memory path.
- Results are buffered in an in-order FIFO and drained one per cycle into the regfile's single write port (rd/data/wren).
- It also keeps a 32-bit busy scoreboard of registers that have an outstanding load, so issue logic can stall on RAW hazards.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, at least 2.
- XLEN, 32, data width.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- alu_valid_i  in  1  ALU result valid.
- alu_rd_i  in  5  ALU destination register.
- alu_data_i  in  XLEN  ALU result.
- alu_ready_o  out  1  ALU result accepted this cycle.
- mem_valid_i  in  1  load result valid.
- mem_rd_i  in  5  load destination register.
- mem_data_i  in  XLEN  load result.
- mem_ready_o  out  1  load result accepted this cycle.
- issue_i  in  1  load issued; marks its destination busy.
- issue_rd_i  in  5  destination of the issued load.
- wb_stall_i  in  1  freeze draining; FIFO head is held.
- rd_o  out  5  to regfile rd_i.
- datord_o  out  XLEN  to regfile datord_i.
- wren_o  out  1  to regfile wren_i.
- busy_o  out  32  scoreboard; bit n = register xn has a pending load.
- count_o  out  $clog2(DEPTH)+1  current FIFO occupancy.
- full_o  out  1  count_o == DEPTH.
- fwd_rs_i  in  5  forwarding lookup register (WB_FWD_EN only).
- fwd_hit_o  out  1  lookup hit (WB_FWD_EN only).
- fwd_data_o  out  XLEN  forwarded data (WB_FWD_EN only).

Behaviour:
- Reset: FIFO empty, count_o=0, full_o=0, wren_o=0, rd_o=0, datord_o=0, busy_o=0, fwd_hit_o=0, fwd_data_o=0. Reset asserted mid-operation discards all queued entries and clears the scoreboard on that edge.
- Entry format: {src (0=ALU, 1=MEM), rd, data}. At most one push per cycle.
- Arbitration: MEM has priority over ALU. The losing source sees ready low and must hold its valid, rd and data.
- Push condition, per source: (source wins arbitration) AND (!full_o OR pop this cycle).
- ready_o is combinational and follows the push condition. When both sources are idle, each ready_o shows whether that source would be accepted.
- Writes to x0: accepted (ready high) but not enqueued.
  - A MEM write to x0 still completes its handshake.
- Drain: pop = !empty && !wb_stall_i.
  - wren_o = pop, combinational.
  - rd_o and datord_o come from the FIFO head; they are 0 when empty.
  - The regfile commits on the same edge that pops the entry.
  - Latency: accepted at edge N → wren_o high in cycle N+1 → written at edge N+1, assuming the FIFO was empty and there is no stall.
- Ordering: strict FIFO. Two queued writes to the same rd commit in acceptance order.
- Full with a simultaneous pop: the push is accepted and count is unchanged.
- Empty: no pop. wb_stall_i has no effect while empty.
- Scoreboard set: issue_i with issue_rd_i≠0 sets busy_o[issue_rd_i] on the edge.
- Scoreboard clear: popping an entry with src=MEM clears busy_o[rd] on the edge.
- Scoreboard conflict: if a set and a clear hit the same register on the same edge, set wins.
- busy_o[0] is always 0.
- A popped ALU entry never touches busy_o.
- count_o range is 0..DEPTH. Pointers wrap modulo DEPTH.

Optional Feature:
- Macro: WB_FWD_EN.
- Defined: fwd_hit_o=1 when any valid FIFO entry has rd==fwd_rs_i and fwd_rs_i≠0.
  - fwd_data_o = data of the youngest matching entry.
  - Lookup is combinational over the registered FIFO contents.
  - An entry pushed this cycle is not visible until the next cycle.
- Undefined: fwd_hit_o and fwd_data_o are tied to 0, and fwd_rs_i is ignored. The port list is unchanged.

Test Plan:
- Single write: alu_valid_i=1, alu_rd_i=5, alu_data_i=0x1234 for one cycle. Required: wren_o=1, rd_o=5, datord_o=0x1234 in the next cycle only; count_o returns to 0.
- Arbitration: ALU (rd=3) and MEM (rd=4) valid in the same cycle. Required: mem_ready_o=1, alu_ready_o=0. ALU is accepted the next cycle; writes commit in order rd=4 then rd=3.
- Fill/full: DEPTH=4, wb_stall_i=1, push 5 ALU writes on consecutive cycles. Required: count_o=4, full_o=1, and alu_ready_o=0 on the 5th. Releasing the stall accepts the 5th and drains all 5 in order.
- Scoreboard: issue_i with rd=7, then MEM result rd=7=0xAA. Required: busy_o[7]=1 until the pop edge, then 0. Repeating with a same-cycle re-issue of rd=7 on the pop edge leaves busy_o[7]=1.
- x0 and reset: MEM write rd=0. Required: mem_ready_o=1, no wren_o. Then queue 3 entries and assert rst_i. Required: count_o=0, wren_o=0, busy_o=0 the next cycle.
- WB_FWD_EN: queue rd=9=0x11 then rd=9=0x22 under stall, with fwd_rs_i=9. Required: fwd_hit_o=1, fwd_data_o=0x22. With fwd_rs_i=0: fwd_hit_o=0.
